// File: rtl/bp_be_pkg.sv
// ============================================================================
// Module  : bp_be_pkg
// Brief   : Shared BE types for stall accounting: reason codes, controller
//           commands, controller states and counter-bank entry indices.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bp_be_pkg;

  // Encoded stall reasons reported by the commit point
  typedef enum logic [4:0] {
    e_fe_cmd           = 5'd0,
    e_fe_cmd_fence     = 5'd1,
    e_mispredict       = 5'd2,
    e_dtlb_miss        = 5'd3,
    e_dcache_miss      = 5'd4,
    e_dcache_rollback  = 5'd5,
    e_long_haul        = 5'd6,
    e_exception        = 5'd7,
    e_eret             = 5'd8,
    e_control_haz      = 5'd9,
    e_data_haz         = 5'd10,
    e_aux_dep          = 5'd11,
    e_load_dep         = 5'd12,
    e_mul_dep          = 5'd13,
    e_fma_dep          = 5'd14,
    e_sb_dep           = 5'd15,
    e_struct_haz       = 5'd16,
    e_itlb_miss        = 5'd17,
    e_icache_miss      = 5'd18,
    e_branch_override  = 5'd19,
    e_ret_override     = 5'd20
  } bp_stall_reason_e;

  typedef enum logic [0:0] {
    e_stall_cmd_dump  = 1'b0,
    e_stall_cmd_clear = 1'b1
  } bp_stall_cmd_e;

  typedef enum logic [1:0] {
    e_idle = 2'd0,
    e_snap = 2'd1,
    e_dump = 2'd2
  } bp_stall_ctrl_state_e;

  // Counter bank layout: reasons first, then committed instructions, then unknown
  localparam int stall_num_reasons_lp  = 21;
  localparam int stall_instr_idx_lp    = stall_num_reasons_lp;
  localparam int stall_unknown_idx_lp  = stall_num_reasons_lp + 1;
  localparam int stall_num_entries_lp  = stall_num_reasons_lp + 2;
  localparam int stall_idx_width_lp    = 5;

endpackage

`default_nettype wire

// File: rtl/bp_be_sat_counter.sv
// ============================================================================
// Module  : bp_be_sat_counter
// Brief   : Up-counter that sticks at all-ones; synchronous clear wins over
//           increment.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_be_sat_counter
  import bp_be_pkg::*;
#(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               inc_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_r;

  // Count up unless already saturated; clear takes priority
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_r <= '0;
    end else if (clear_i) begin
      count_r <= '0;
    end else if (inc_i && (count_r != '1)) begin
      count_r <= count_r + width_p'(1);
    end
  end

  assign count_o = count_r;

endmodule

`default_nettype wire

// File: rtl/bp_be_stall_counter_ctrl.sv
// ============================================================================
// Module  : bp_be_stall_counter_ctrl
// Brief   : Per-cycle commit/stall classifier feeding a live saturating
//           counter bank, with snapshot-and-stream dump and clear commands.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_be_stall_counter_ctrl
  import bp_be_pkg::*;
#(
  parameter int num_reasons_p = stall_num_reasons_lp,
  parameter int cnt_width_p   = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   freeze_i,
  input  logic                   commit_v_i,
  input  logic                   stall_v_i,
  input  logic [4:0]             stall_reason_i,
  input  logic                   cmd_v_i,
  input  logic                   cmd_i,
  output logic                   cmd_ready_o,
  output logic                   busy_o,
  output logic                   dump_v_o,
  output logic [4:0]             dump_idx_o,
  output logic [cnt_width_p-1:0] dump_count_o,
  output logic                   dump_last_o,
  input  logic                   dump_ready_i
);

  localparam int instr_idx_lp   = num_reasons_p;
  localparam int unknown_idx_lp = num_reasons_p + 1;
  localparam int num_entries_lp = num_reasons_p + 2;

  bp_stall_ctrl_state_e state_r, state_n;
  logic [4:0]             idx_r;
  logic [num_entries_lp-1:0] inc_li;
  logic                   clear_li;
  logic                   idx_last;
  logic [cnt_width_p-1:0] live_cnt [num_entries_lp];
  logic [cnt_width_p-1:0] snap_r   [num_entries_lp];

  assign idx_last = (idx_r == 5'(num_entries_lp - 1));
  assign clear_li = (state_r == e_idle) && cmd_v_i
                 && (bp_stall_cmd_e'(cmd_i) == e_stall_cmd_clear);

  // One-hot increment select: commit, then valid in-range reason, else unknown
  always_comb begin
    inc_li = '0;
    if (!freeze_i) begin
      if (commit_v_i) begin
        inc_li[instr_idx_lp] = 1'b1;
      end else if (stall_v_i && (stall_reason_i < 5'(num_reasons_p))) begin
        inc_li[stall_reason_i] = 1'b1;
      end else begin
        inc_li[unknown_idx_lp] = 1'b1;
      end
    end
  end

  for (genvar e = 0; e < num_entries_lp; e++) begin : g_live
    bp_be_sat_counter #(
      .width_p (cnt_width_p)
    ) u_cnt (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .clear_i   (clear_li),
      .inc_i     (inc_li[e]),
      .count_o   (live_cnt[e])
    );
  end

  // Controller state register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_idle;
    end else begin
      state_r <= state_n;
    end
  end

  // Next state and handshake/dump outputs; dump fields read zero outside e_dump
  always_comb begin
    state_n      = state_r;
    cmd_ready_o  = 1'b0;
    busy_o       = 1'b1;
    dump_v_o     = 1'b0;
    dump_idx_o   = '0;
    dump_count_o = '0;
    dump_last_o  = 1'b0;
    case (state_r)
      e_idle: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (cmd_v_i && (bp_stall_cmd_e'(cmd_i) == e_stall_cmd_dump)) begin
          state_n = e_snap;
        end
      end
      e_snap: begin
        state_n = e_dump;
      end
      e_dump: begin
        dump_v_o     = 1'b1;
        dump_idx_o   = idx_r;
        dump_count_o = snap_r[idx_r];
        dump_last_o  = idx_last;
        if (dump_ready_i && idx_last) begin
          state_n = e_idle;
        end
      end
      default: begin
        state_n = e_idle;
      end
    endcase
  end

  // Snapshot captures pre-increment live values; index walks on each handshake
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      idx_r  <= '0;
      snap_r <= '{default: '0};
    end else if (state_r == e_snap) begin
      idx_r  <= '0;
      snap_r <= live_cnt;
    end else if ((state_r == e_dump) && dump_ready_i) begin
      idx_r <= idx_last ? 5'd0 : idx_r + 5'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bp_be_stall_counter_ctrl.sv
// ============================================================================
// Module  : tb_bp_be_stall_counter_ctrl
// Brief   : Self-checking bench; two instances (32-bit and 4-bit counters)
//           share stimulus and are compared against an unbounded count model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bp_be_stall_counter_ctrl;

  localparam int NR = 21;
  localparam int NE = NR + 2;
  localparam int WA = 32;
  localparam int WB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, freeze, commit, stall_v, cmd_v, cmd, ready;
  logic [4:0] reason;

  logic          a_cmd_ready, a_busy, a_dump_v, a_last;
  logic [4:0]    a_idx;
  logic [WA-1:0] a_count;
  logic          b_cmd_ready, b_busy, b_dump_v, b_last;
  logic [4:0]    b_idx;
  logic [WB-1:0] b_count;

  bp_be_stall_counter_ctrl #(.num_reasons_p(NR), .cnt_width_p(WA)) dut_a (
    .clk_i(clk), .reset_n_i(reset_n), .freeze_i(freeze), .commit_v_i(commit),
    .stall_v_i(stall_v), .stall_reason_i(reason), .cmd_v_i(cmd_v), .cmd_i(cmd),
    .cmd_ready_o(a_cmd_ready), .busy_o(a_busy), .dump_v_o(a_dump_v),
    .dump_idx_o(a_idx), .dump_count_o(a_count), .dump_last_o(a_last),
    .dump_ready_i(ready)
  );

  bp_be_stall_counter_ctrl #(.num_reasons_p(NR), .cnt_width_p(WB)) dut_b (
    .clk_i(clk), .reset_n_i(reset_n), .freeze_i(freeze), .commit_v_i(commit),
    .stall_v_i(stall_v), .stall_reason_i(reason), .cmd_v_i(cmd_v), .cmd_i(cmd),
    .cmd_ready_o(b_cmd_ready), .busy_o(b_busy), .dump_v_o(b_dump_v),
    .dump_idx_o(b_idx), .dump_count_o(b_count), .dump_last_o(b_last),
    .dump_ready_i(ready)
  );

  int errors = 0;
  int checks = 0;

  // Reference: unbounded event counts per entry; saturation applied on compare
  longint cnt  [NE];
  longint snap [NE];
  bit     m_busy = 1'b0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  // Apply this cycle's inputs to the model, then advance to just after the edge
  task automatic cycle();
    bit clr;
    clr = cmd_v && cmd && !m_busy;
    if (!freeze) begin
      if (commit)                         cnt[NR]++;
      else if (stall_v && (reason < NR))  cnt[reason]++;
      else                                cnt[NR+1]++;
    end
    if (clr) foreach (cnt[i]) cnt[i] = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    freeze  = ($urandom_range(0, 9) == 0);
    commit  = ($urandom_range(0, 2) == 0);
    stall_v = ($urandom_range(0, 3) != 0);
    reason  = 5'($urandom_range(0, 31));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, a_cmd_ready, 1);
    chk({tag, "_busy"},  a_busy, 0);
    chk({tag, "_v"},     a_dump_v, 0);
    chk({tag, "_bv"},    b_dump_v, 0);
  endtask

  // Issue a dump and follow the stream; mode 0 ready=1, 1 toggling, 2 random
  task automatic do_dump(input int mode, input int abort_at, input bit rnd, input bit r7);
    int k = 0;
    int guard = 0;
    bit tgl = 1'b1;
    bit aborted = 1'b0;
    cmd_v = 1'b1;
    cmd   = 1'b0;
    chk("acc_ready", a_cmd_ready, 1);
    cycle();
    m_busy = 1'b1;
    cmd_v  = !rnd;
    cmd    = 1'b1;
    foreach (cnt[i]) snap[i] = cnt[i];
    chk("snap_busy",  a_busy, 1);
    chk("snap_v",     a_dump_v, 0);
    chk("snap_ready", a_cmd_ready, 0);
    if (r7) begin
      freeze = 1'b0; commit = 1'b0; stall_v = 1'b1; reason = 5'd7;
    end else if (rnd) begin
      rand_inputs();
    end
    cycle();
    if (r7) begin
      freeze = 1'b1; stall_v = 1'b0;
    end
    while (k < NE && guard < 400 && !aborted) begin
      guard++;
      if (rnd) begin
        rand_inputs();
        cmd_v = ($urandom_range(0, 3) == 0);
        cmd   = 1'($urandom_range(0, 1));
      end
      case (mode)
        0:       ready = 1'b1;
        1:       begin ready = tgl; tgl = !tgl; end
        default: ready = ($urandom_range(0, 2) != 0);
      endcase
      chk("dump_v",     a_dump_v, 1);
      chk("dump_idx",   a_idx, k);
      chk("dump_cnt",   a_count, sat(snap[k], WA));
      chk("dump_cnt4",  b_count, sat(snap[k], WB));
      chk("dump_last",  a_last, (k == NE - 1));
      chk("dump_busy",  a_busy, 1);
      chk("dump_cmdrdy", a_cmd_ready, 0);
      if (k == abort_at) begin
        reset_n = 1'b0;
        #1;
        chk("abort_v",     a_dump_v, 0);
        chk("abort_bv",    b_dump_v, 0);
        chk("abort_busy",  a_busy, 0);
        chk("abort_ready", a_cmd_ready, 1);
        chk("abort_idx",   a_idx, 0);
        foreach (cnt[i]) cnt[i] = 0;
        m_busy  = 1'b0;
        cmd_v   = 1'b0;
        aborted = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
      end else begin
        cycle();
        if (ready) k++;
      end
    end
    m_busy = 1'b0;
    cmd_v  = 1'b0;
    ready  = 1'b0;
    if (aborted) begin
      cycle();
    end else begin
      chk("dump_done", k, NE);
    end
    check_idle("post_dump");
  endtask

  initial begin
    reset_n = 1'b0; freeze = 1'b1; commit = 1'b0; stall_v = 1'b0;
    reason = 5'd0; cmd_v = 1'b0; cmd = 1'b0; ready = 1'b0;
    foreach (cnt[i]) cnt[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", a_cmd_ready, 1);
    chk("rst_busy",  a_busy, 0);
    chk("rst_v",     a_dump_v, 0);
    chk("rst_idx",   a_idx, 0);
    chk("rst_cnt",   a_count, 0);
    chk("rst_last",  a_last, 0);
    @(negedge clk);
    reset_n = 1'b1;
    cycle();
    check_idle("idle0");

    // Directed: 5 commits, 3 reason-4 stalls, 2 unattributed cycles
    freeze = 1'b0;
    commit = 1'b1;
    repeat (5) cycle();
    commit = 1'b0; stall_v = 1'b1; reason = 5'd4;
    repeat (3) cycle();
    stall_v = 1'b0;
    repeat (2) cycle();
    freeze = 1'b1;
    do_dump(0, -1, 1'b0, 1'b0);

    // Increment during the snapshot cycle shows up only in the next dump
    do_dump(0, -1, 1'b0, 1'b1);
    do_dump(0, -1, 1'b0, 1'b0);

    // Backpressure with alternating ready
    do_dump(1, -1, 1'b0, 1'b0);

    // Clear racing a commit
    freeze = 1'b0; commit = 1'b1; cmd_v = 1'b1; cmd = 1'b1;
    chk("clr_ready", a_cmd_ready, 1);
    cycle();
    cmd_v = 1'b0; commit = 1'b0; freeze = 1'b1;
    do_dump(0, -1, 1'b0, 1'b0);

    // Saturation of the narrow instance, then frozen cycles
    freeze = 1'b0; commit = 1'b1;
    repeat (20) cycle();
    freeze = 1'b1;
    for (int i = 0; i < 10; i++) begin
      commit  = 1'($urandom_range(0, 1));
      stall_v = 1'($urandom_range(0, 1));
      cycle();
    end
    commit = 1'b0; stall_v = 1'b0;
    do_dump(0, -1, 1'b0, 1'b0);

    // Reset mid-dump, then confirm a clean bank
    do_dump(0, 9, 1'b0, 1'b0);
    freeze = 1'b1;
    do_dump(0, -1, 1'b0, 1'b0);

    // Randomized traffic with occasional clears and random-backpressure dumps
    for (int it = 0; it < 25; it++) begin
      int n;
      n = $urandom_range(10, 40);
      for (int c = 0; c < n; c++) begin
        rand_inputs();
        cmd_v = ($urandom_range(0, 15) == 0);
        cmd   = 1'b1;
        check_idle("rnd_idle");
        cycle();
      end
      cmd_v = 1'b0;
      do_dump(2, -1, 1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
